// File: rtl/dest_reg_track_if.sv
// Bundle of EX/ID pipeline inputs and the forwarding, stall and write-port outputs
// of the destination-register tracker.
interface dest_reg_track_if #(
   parameter int unsigned AW = 5,
   parameter int unsigned CW = 16
);
   logic          hold;
   logic          flush;
   logic          ex_valid;
   logic          ex_regwrite;
   logic          ex_load;
   logic [AW-1:0] ex_wreg;
   logic [AW-1:0] ex_rs;
   logic [AW-1:0] ex_rt;
   logic [AW-1:0] id_rs;
   logic [AW-1:0] id_rt;
   logic          id_valid;
   logic [1:0]    fwd_a;
   logic [1:0]    fwd_b;
   logic          stall_req;
   logic          wb_we;
   logic [AW-1:0] wb_wreg;
   logic [AW-1:0] mem_wreg;
   logic [CW-1:0] stall_cnt;

   modport master (
      output hold, flush, ex_valid, ex_regwrite, ex_load, ex_wreg, ex_rs, ex_rt,
             id_rs, id_rt, id_valid,
      input  fwd_a, fwd_b, stall_req, wb_we, wb_wreg, mem_wreg, stall_cnt
   );

   modport slave (
      input  hold, flush, ex_valid, ex_regwrite, ex_load, ex_wreg, ex_rs, ex_rt,
             id_rs, id_rt, id_valid,
      output fwd_a, fwd_b, stall_req, wb_we, wb_wreg, mem_wreg, stall_cnt
   );
endinterface

// File: rtl/dest_reg_track.sv
// Carries the EX destination register through MEM and WB, drives the regfile write port,
// EX operand forwarding selects and the load-use stall request with a saturating stall counter.
module dest_reg_track #(
   parameter int unsigned AW = 5,
   parameter int unsigned CW = 16
) (
   input logic              clk,
   input logic              rst,
   dest_reg_track_if.slave  bus
);
   typedef struct packed {
      logic          valid;
      logic          regwrite;
      logic          load;
      logic [AW-1:0] wreg;
   } mem_slot_t;

   typedef struct packed {
      logic          valid;
      logic          regwrite;
      logic [AW-1:0] wreg;
   } wb_slot_t;

   mem_slot_t     mem_d, mem_q;
   wb_slot_t      wb_d, wb_q;
   logic [CW-1:0] stall_cnt_d, stall_cnt_q;
   logic          stall_raw;
   logic          mem_fwd_ok, wb_fwd_ok;

   // Loads in MEM have no data yet, so they never act as a forwarding source.
   assign mem_fwd_ok = mem_q.valid & mem_q.regwrite & ~mem_q.load & (mem_q.wreg != '0);
   assign wb_fwd_ok  = wb_q.valid & wb_q.regwrite & (wb_q.wreg != '0);

   assign stall_raw = bus.ex_valid & ~bus.flush & bus.ex_load & bus.ex_regwrite &
                      (bus.ex_wreg != '0) & bus.id_valid &
                      ((bus.ex_wreg == bus.id_rs) | (bus.ex_wreg == bus.id_rt));

   always_comb begin
      mem_d       = mem_q;
      wb_d        = wb_q;
      stall_cnt_d = stall_cnt_q;
      if (!bus.hold) begin
         if (bus.ex_valid && !bus.flush) begin
            mem_d = '{valid: 1'b1, regwrite: bus.ex_regwrite, load: bus.ex_load,
                      wreg: bus.ex_wreg};
         end else begin
            mem_d = '0;
         end
         wb_d = '{valid: mem_q.valid, regwrite: mem_q.regwrite, wreg: mem_q.wreg};
         if (stall_raw && (stall_cnt_q != {CW{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q       <= '0;
         wb_q        <= '0;
         stall_cnt_q <= '0;
      end else begin
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      bus.fwd_a = 2'b00;
      bus.fwd_b = 2'b00;
      if (!rst) begin
         if (mem_fwd_ok && (mem_q.wreg == bus.ex_rs))     bus.fwd_a = 2'b10;
         else if (wb_fwd_ok && (wb_q.wreg == bus.ex_rs))  bus.fwd_a = 2'b01;
         if (mem_fwd_ok && (mem_q.wreg == bus.ex_rt))     bus.fwd_b = 2'b10;
         else if (wb_fwd_ok && (wb_q.wreg == bus.ex_rt))  bus.fwd_b = 2'b01;
      end
   end

   // Slot state is already cleared by rst; the gating covers the input-driven outputs.
   assign bus.stall_req = stall_raw & ~rst;
   assign bus.wb_we     = wb_fwd_ok & ~rst;
   assign bus.wb_wreg   = rst ? '0 : wb_q.wreg;
   assign bus.mem_wreg  = rst ? '0 : mem_q.wreg;
   assign bus.stall_cnt = rst ? '0 : stall_cnt_q;
endmodule
